rx_link_fault_ctrl: RTL and testbench

//  Link-fault sequencer for the 10G RS receive path (802.3ae cl.46 style). Consumes
//  per-column local/remote fault flags from the RS receive front end. Qualifies them

---
 rtl/rx_link_fault_ctrl_pkg.sv | 26 ++
 rtl/rx_sat_cnt.sv | 21 ++
 rtl/rx_link_fault_ctrl.sv | 114 +++++++++++
 tb/tb_rx_link_fault_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rx_link_fault_ctrl_pkg.sv
// rtl/rx_link_fault_ctrl_pkg.sv - shared encodings and column classifier for the RS link-fault sequencer
package rx_link_fault_ctrl_pkg;

   typedef enum logic [1:0] {
      LF_OK     = 2'b00,
      LF_LOCAL  = 2'b01,
      LF_REMOTE = 2'b10
   } lf_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'b00,
      ST_COUNT = 2'b01,
      ST_FAULT = 2'b10
   } state_t;

   localparam logic [7:0] SEQUENCE = 8'h59;

   // Local fault wins when both flags are present in the same column.
   function automatic lf_t col_type_of(input logic valid, input logic lf, input logic rf);
      if (!valid)  return LF_OK;
      else if (lf) return LF_LOCAL;
      else if (rf) return LF_REMOTE;
      else         return LF_OK;
   endfunction

endpackage

// File: rtl/rx_sat_cnt.sv
// rtl/rx_sat_cnt.sv - saturating event counter with synchronous clear
module rx_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc && (q != {CNT_W{1'b1}}))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/rx_link_fault_ctrl.sv
// rtl/rx_link_fault_ctrl.sv - qualifies RS receive fault columns into link status and TX control
module rx_link_fault_ctrl
   import rx_link_fault_ctrl_pkg::*;
#(
   parameter int COL_WINDOW = 128,
   parameter int SEQ_THRESH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             rxclk,
   input  logic             reset_n,
   input  logic             col_valid,
   input  logic             local_fault,
   input  logic             remote_fault,
   input  logic             stat_clr,
   output logic [1:0]       link_fault,
   output logic             link_ok,
   output logic             tx_send_rf,
   output logic             tx_send_idle,
   output logic             fault_event,
   output logic [CNT_W-1:0] local_cnt,
   output logic [CNT_W-1:0] remote_cnt
);

   localparam int COL_W = $clog2(COL_WINDOW) + 1;
   localparam int SEQ_W = $clog2(SEQ_THRESH) + 1;

   state_t           state;
   lf_t              last_type;
   lf_t              col_type;
   lf_t              link_q;
   lf_t              link_nxt;
   logic [COL_W-1:0] col_cnt;
   logic [SEQ_W-1:0] seq_cnt;
   logic             is_fault, same_type, seq_hit, col_hit, fire, expire;

   assign col_type  = col_type_of(col_valid, local_fault, remote_fault);
   assign is_fault  = (col_type != LF_OK);
   assign same_type = is_fault && (col_type == last_type);
   assign seq_hit   = ((seq_cnt + 1'b1) == SEQ_W'(SEQ_THRESH));
   assign col_hit   = ((col_cnt + 1'b1) == COL_W'(COL_WINDOW));
   assign fire      = (state == ST_COUNT) && same_type && seq_hit;
   assign expire    = col_valid && !is_fault && (state != ST_INIT) && col_hit;

   // Status only moves on a qualified fault or on window expiry; otherwise it holds.
   always_comb begin
      link_nxt = link_q;
      if (fire)        link_nxt = last_type;
      else if (expire) link_nxt = LF_OK;
   end

   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_INIT;
         last_type    <= LF_OK;
         seq_cnt      <= '0;
         col_cnt      <= '0;
         link_q       <= LF_OK;
         link_ok      <= 1'b1;
         tx_send_rf   <= 1'b0;
         tx_send_idle <= 1'b0;
         fault_event  <= 1'b0;
      end else begin
         link_q       <= link_nxt;
         link_ok      <= (link_nxt == LF_OK);
         tx_send_rf   <= (link_nxt == LF_LOCAL);
         tx_send_idle <= (link_nxt == LF_REMOTE);
         fault_event  <= fire;
         if (col_valid) begin
            if (is_fault && !same_type) begin
               state     <= ST_COUNT;
               last_type <= col_type;
               seq_cnt   <= SEQ_W'(1);
               col_cnt   <= '0;
            end else if (same_type) begin
               col_cnt <= '0;
               if (fire) begin
                  state   <= ST_FAULT;
                  seq_cnt <= '0;
               end else if (state == ST_COUNT) begin
                  seq_cnt <= seq_cnt + 1'b1;
               end
            end else if (state != ST_INIT) begin
               if (col_hit) begin
                  state     <= ST_INIT;
                  last_type <= LF_OK;
                  seq_cnt   <= '0;
                  col_cnt   <= '0;
               end else begin
                  col_cnt <= col_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign link_fault = link_q;

   rx_sat_cnt #(.CNT_W(CNT_W)) u_local_cnt (
      .clk     (rxclk),
      .reset_n (reset_n),
      .inc     (fire && (last_type == LF_LOCAL)),
      .clr     (stat_clr),
      .q       (local_cnt)
   );

   rx_sat_cnt #(.CNT_W(CNT_W)) u_remote_cnt (
      .clk     (rxclk),
      .reset_n (reset_n),
      .inc     (fire && (last_type == LF_REMOTE)),
      .clr     (stat_clr),
      .q       (remote_cnt)
   );

endmodule

// File: tb/tb_rx_link_fault_ctrl.sv
// tb/tb_rx_link_fault_ctrl.sv - directed self-checking bench for rx_link_fault_ctrl
module tb_rx_link_fault_ctrl;

   logic        rxclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        col_valid = 1'b0;
   logic        local_fault = 1'b0;
   logic        remote_fault = 1'b0;
   logic        stat_clr = 1'b0;
   logic [1:0]  link_fault, s_link_fault;
   logic        link_ok, tx_send_rf, tx_send_idle, fault_event;
   logic        s_link_ok, s_tx_send_rf, s_tx_send_idle, s_fault_event;
   logic [15:0] local_cnt, remote_cnt;
   logic [3:0]  s_local_cnt, s_remote_cnt;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 rxclk = ~rxclk;

   rx_link_fault_ctrl dut (
      .rxclk(rxclk), .reset_n(reset_n), .col_valid(col_valid),
      .local_fault(local_fault), .remote_fault(remote_fault), .stat_clr(stat_clr),
      .link_fault(link_fault), .link_ok(link_ok), .tx_send_rf(tx_send_rf),
      .tx_send_idle(tx_send_idle), .fault_event(fault_event),
      .local_cnt(local_cnt), .remote_cnt(remote_cnt)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   rx_link_fault_ctrl #(.CNT_W(4)) dut_sat (
      .rxclk(rxclk), .reset_n(reset_n), .col_valid(col_valid),
      .local_fault(local_fault), .remote_fault(remote_fault), .stat_clr(stat_clr),
      .link_fault(s_link_fault), .link_ok(s_link_ok), .tx_send_rf(s_tx_send_rf),
      .tx_send_idle(s_tx_send_idle), .fault_event(s_fault_event),
      .local_cnt(s_local_cnt), .remote_cnt(s_remote_cnt)
   );

   task automatic col(input logic v, input logic lf, input logic rf);
      col_valid = v; local_fault = lf; remote_fault = rf;
      @(posedge rxclk);
      @(negedge rxclk);
   endtask

   task automatic test_reset();
      n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL reset_link_fault: got %b expected 00", link_fault); end
      n_cmp++; if (link_ok !== 1'b1) begin n_bad++; $display("FAIL reset_link_ok: got %b expected 1", link_ok); end
      n_cmp++; if ({tx_send_rf, tx_send_idle, fault_event} !== 3'b000) begin n_bad++; $display("FAIL reset_tx_event: got %b expected 000", {tx_send_rf, tx_send_idle, fault_event}); end
      n_cmp++; if ({local_cnt, remote_cnt} !== 32'h0) begin n_bad++; $display("FAIL reset_counts: got %h expected 0", {local_cnt, remote_cnt}); end
   endtask

   task automatic test_local_fault();
      for (int i = 0; i < 3; i++) begin
         col(1, 1, 0);
         n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL lf_early_%0d: got %b expected 00", i, link_fault); end
      end
      col(1, 1, 0);
      n_cmp++; if (link_fault !== 2'b01) begin n_bad++; $display("FAIL lf_link_fault: got %b expected 01", link_fault); end
      n_cmp++; if ({link_ok, tx_send_rf, tx_send_idle} !== 3'b010) begin n_bad++; $display("FAIL lf_ok_tx: got %b expected 010", {link_ok, tx_send_rf, tx_send_idle}); end
      n_cmp++; if (fault_event !== 1'b1) begin n_bad++; $display("FAIL lf_event: got %b expected 1", fault_event); end
      n_cmp++; if (local_cnt !== 16'd1) begin n_bad++; $display("FAIL lf_local_cnt: got %0d expected 1", local_cnt); end
   endtask

   task automatic test_fault_expiry();
      for (int i = 0; i < 127; i++) begin
         col(1, 0, 0);
         n_cmp++; if (link_fault !== 2'b01) begin n_bad++; $display("FAIL fexp_hold_%0d: got %b expected 01", i, link_fault); end
      end
      n_cmp++; if (fault_event !== 1'b0) begin n_bad++; $display("FAIL fexp_event_pulse: got %b expected 0", fault_event); end
      col(1, 0, 0);
      n_cmp++; if ({link_fault, link_ok, tx_send_rf} !== 4'b0010) begin n_bad++; $display("FAIL fexp_cleared: got %b expected 0010", {link_fault, link_ok, tx_send_rf}); end
   endtask

   task automatic test_count_expiry();
      for (int i = 0; i < 3; i++) col(1, 1, 0);
      for (int i = 0; i < 128; i++) begin
         col(1, 0, 0);
         n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL cexp_nf_%0d: got %b expected 00", i, link_fault); end
      end
      for (int i = 0; i < 3; i++) begin
         col(1, 1, 0);
         n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL cexp_restart_%0d: got %b expected 00", i, link_fault); end
      end
      col(1, 1, 0);
      n_cmp++; if (link_fault !== 2'b01 || local_cnt !== 16'd2) begin n_bad++; $display("FAIL cexp_refault: got %b/%0d expected 01/2", link_fault, local_cnt); end
      for (int i = 0; i < 128; i++) col(1, 0, 0);
      n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL cexp_clear: got %b expected 00", link_fault); end
   endtask

   task automatic test_type_change();
      col(1, 1, 0); col(1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         col(1, 0, 1);
         n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL tc_rf_early_%0d: got %b expected 00", i, link_fault); end
      end
      col(1, 0, 1);
      n_cmp++; if ({link_fault, tx_send_idle, tx_send_rf, fault_event} !== 5'b10101) begin n_bad++; $display("FAIL tc_remote: got %b expected 10101", {link_fault, tx_send_idle, tx_send_rf, fault_event}); end
      n_cmp++; if (remote_cnt !== 16'd1 || local_cnt !== 16'd2) begin n_bad++; $display("FAIL tc_counts: got %0d/%0d expected 1/2", remote_cnt, local_cnt); end
      for (int i = 0; i < 3; i++) begin
         col(1, 1, 0);
         n_cmp++; if (link_fault !== 2'b10) begin n_bad++; $display("FAIL tc_hold_old_%0d: got %b expected 10", i, link_fault); end
      end
      col(1, 1, 0);
      n_cmp++; if ({link_fault, fault_event} !== 3'b011 || local_cnt !== 16'd3) begin n_bad++; $display("FAIL tc_to_local: got %b/%0d expected 011/3", {link_fault, fault_event}, local_cnt); end
      for (int i = 0; i < 128; i++) col(1, 0, 0);
      n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL tc_clear: got %b expected 00", link_fault); end
   endtask

   task automatic test_both_flags();
      for (int i = 0; i < 3; i++) begin
         col(1, 1, 1);
         col(0, 1, 1);
         col(0, 0, 1);
         n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL both_early_%0d: got %b expected 00", i, link_fault); end
      end
      col(1, 1, 1);
      n_cmp++; if ({link_fault, fault_event} !== 3'b011 || local_cnt !== 16'd4 || remote_cnt !== 16'd1) begin n_bad++; $display("FAIL both_fault: got %b/%0d/%0d expected 011/4/1", {link_fault, fault_event}, local_cnt, remote_cnt); end
      for (int i = 0; i < 200; i++) col(0, 0, 0);
      n_cmp++; if ({link_fault, fault_event} !== 3'b010) begin n_bad++; $display("FAIL both_invalid_hold: got %b expected 010", {link_fault, fault_event}); end
      for (int i = 0; i < 127; i++) begin col(1, 0, 0); col(0, 0, 0); end
      n_cmp++; if (link_fault !== 2'b01) begin n_bad++; $display("FAIL both_window_127: got %b expected 01", link_fault); end
      col(1, 0, 0);
      n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL both_window_128: got %b expected 00", link_fault); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) col(1, 1, 0);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if ({link_fault, link_ok, tx_send_rf, tx_send_idle, fault_event} !== 6'b001000) begin n_bad++; $display("FAIL rst_mid_outputs: got %b expected 001000", {link_fault, link_ok, tx_send_rf, tx_send_idle, fault_event}); end
      n_cmp++; if ({local_cnt, remote_cnt} !== 32'h0) begin n_bad++; $display("FAIL rst_mid_counts: got %h expected 0", {local_cnt, remote_cnt}); end
      @(negedge rxclk);
      reset_n = 1'b1;
      col(1, 1, 0);
      n_cmp++; if (link_fault !== 2'b00) begin n_bad++; $display("FAIL rst_mid_restart: got %b expected 00", link_fault); end
      for (int i = 0; i < 3; i++) col(1, 1, 0);
      n_cmp++; if (link_fault !== 2'b01 || local_cnt !== 16'd1) begin n_bad++; $display("FAIL rst_mid_refault: got %b/%0d expected 01/1", link_fault, local_cnt); end
      for (int i = 0; i < 128; i++) col(1, 0, 0);
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 4; i++) col(1, 1, 0);
         for (int i = 0; i < 4; i++) col(1, 0, 1);
      end
      n_cmp++; if (local_cnt !== 16'd17 || remote_cnt !== 16'd16) begin n_bad++; $display("FAIL sat_wide_counts: got %0d/%0d expected 17/16", local_cnt, remote_cnt); end
      n_cmp++; if (s_local_cnt !== 4'hF || s_remote_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_narrow_counts: got %h/%h expected F/F", s_local_cnt, s_remote_cnt); end
      for (int i = 0; i < 3; i++) col(1, 1, 0);
      stat_clr = 1'b1;
      col(1, 1, 0);
      stat_clr = 1'b0;
      n_cmp++; if (fault_event !== 1'b1 || link_fault !== 2'b01) begin n_bad++; $display("FAIL clr_event_seen: got %b/%b expected 1/01", fault_event, link_fault); end
      n_cmp++; if ({local_cnt, remote_cnt} !== 32'h0 || {s_local_cnt, s_remote_cnt} !== 8'h0) begin n_bad++; $display("FAIL clr_priority: got %h/%h expected 0/0", {local_cnt, remote_cnt}, {s_local_cnt, s_remote_cnt}); end
      for (int i = 0; i < 4; i++) col(1, 0, 1);
      n_cmp++; if (local_cnt !== 16'd0 || remote_cnt !== 16'd1 || s_remote_cnt !== 4'd1) begin n_bad++; $display("FAIL clr_recount: got %0d/%0d/%0d expected 0/1/1", local_cnt, remote_cnt, s_remote_cnt); end
   endtask

   initial begin
      repeat (2) @(negedge rxclk);
      test_reset();
      reset_n = 1'b1;
      @(negedge rxclk);
      test_local_fault();
      test_fault_expiry();
      test_count_expiry();
      test_type_change();
      test_both_flags();
      test_reset_mid();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
